// File: rtl/dll_rx_tlp.sv
// Data-link-layer receive buffer: queues PHY frames as TLPs for the Transaction Layer,
// counting accepted and dropped frames. Define DLL_RX_CRC_CHK_EN to drop frames with a non-zero CRC byte.
module dll_rx_tlp #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       dlc_state_i,
    input  logic [135:0]     pipe_rxdata_i,
    input  logic             pipe_rxvalid_i,
    output logic [127:0]     tlp_o,
    output logic             tlp_valid_o,
    input  logic             tlp_ready_i,
    output logic [CNT_W-1:0] rx_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic             overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    logic [127:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic link_up;
    logic crc_ok;
    logic pop;
    logic slot_free;
    logic offer_ok;
    logic push;
    logic drop;
    logic full_drop;

    assign link_up = (dlc_state_i == 2'b11);

`ifdef DLL_RX_CRC_CHK_EN
    assign crc_ok = (pipe_rxdata_i[7:0] == 8'h00);
`else
    logic unused_crc;
    assign unused_crc = ^pipe_rxdata_i[7:0];
    assign crc_ok     = 1'b1;
`endif

    assign tlp_valid_o = (count != '0);
    assign tlp_o       = tlp_valid_o ? mem[rd_ptr] : '0;

    // A same-cycle pop frees a slot, so a full FIFO can still take a frame.
    assign pop       = tlp_valid_o & tlp_ready_i & link_up;
    assign slot_free = (count != DEPTH_L) | pop;
    assign offer_ok  = pipe_rxvalid_i & link_up & crc_ok;
    assign push      = offer_ok & slot_free;
    assign drop      = pipe_rxvalid_i & ~push;
    assign full_drop = offer_ok & ~slot_free;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            rx_cnt_o   <= '0;
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (!link_up) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
            if (push && (rx_cnt_o != '1))
                rx_cnt_o <= rx_cnt_o + 1'b1;
            if (drop && (drop_cnt_o != '1))
                drop_cnt_o <= drop_cnt_o + 1'b1;
            if (full_drop)
                overflow_o <= 1'b1;
        end
    end

    // Storage needs no reset; tlp_o is masked until an entry is written.
    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wr_ptr] <= pipe_rxdata_i[135:8];
    end

endmodule

// File: doc/dll_rx_tlp.md
DLL_RX_TLP -- requirements
Module: dll_rx_tlp

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, power of two >= 2, number of buffered TLP entries.
REQ-002 Parameter CNT_W, default 16, width of the status counters.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port dlc_state_i  input  2  DLCMSM state; 2'b11 = DL_Active.
REQ-006 Port pipe_rxdata_i  input  136  PHY frame: [135:8] TLP, [7:0] CRC byte.
REQ-007 Port pipe_rxvalid_i  input  1  pipe_rxdata_i carries a frame this cycle; no backpressure to PHY.
REQ-008 Port tlp_o  output  128  TLP at FIFO head.
REQ-009 Port tlp_valid_o  output  1  tlp_o valid.
REQ-010 Port tlp_ready_i  input  1  Transaction Layer accepts tlp_o.
REQ-011 Port rx_cnt_o  output  CNT_W  frames accepted into the FIFO.
REQ-012 Port drop_cnt_o  output  CNT_W  frames discarded (inactive, overflow, CRC).
REQ-013 Port overflow_o  output  1  sticky flag: a frame was lost to a full FIFO.

Function
REQ-014 Frame is "offered" in a cycle where pipe_rxvalid_i=1; offer is accepted only if dlc_state_i=2'b11, CRC check passes (REQ-029), and a slot is free.
REQ-015 Accepted frame writes pipe_rxdata_i[135:8] into FIFO tail; CRC byte is discarded.
REQ-016 Latency: frame accepted at edge N -> tlp_valid_o=1 with that TLP after edge N (visible cycle N+1) when FIFO was empty.
REQ-017 tlp_valid_o = FIFO non-empty; tlp_o = head entry, held stable while tlp_valid_o=1 and tlp_ready_i=0.
REQ-018 Pop occurs on an edge where tlp_valid_o=1 and tlp_ready_i=1.
REQ-019 FIFO ordering strictly first-in-first-out; read/write pointers wrap modulo FIFO_DEPTH.
REQ-020 Full boundary: slot-free test uses occupancy after the same-cycle pop; push+pop while full -> push accepted, occupancy unchanged.
REQ-021 Offer while full with no same-cycle pop -> frame dropped, drop_cnt_o+1, overflow_o set to 1.
REQ-022 Offer while dlc_state_i!=2'b11 -> frame dropped, drop_cnt_o+1, overflow_o unchanged.
REQ-023 Link-down flush: any cycle with dlc_state_i!=2'b11 empties the FIFO at that edge; tlp_valid_o=0 from next cycle; pending pops in that cycle are ignored.
REQ-024 rx_cnt_o increments by 1 per accepted frame; drop_cnt_o by 1 per dropped frame; both saturate at all-ones, no wrap.
REQ-025 overflow_o clears only by reset.
REQ-026 No combinational path from pipe_rxvalid_i/pipe_rxdata_i to any output.

Reset
REQ-027 On rising edge with rst_n=0: FIFO empty, pointers 0, tlp_valid_o=0, tlp_o=0, rx_cnt_o=0, drop_cnt_o=0, overflow_o=0.
REQ-028 Reset asserted mid-operation discards all buffered TLPs and any frame offered that cycle, without counting it.

Configuration
REQ-029 Macro DLL_RX_CRC_CHK_EN defined: offer with pipe_rxdata_i[7:0]!=8'h00 is dropped, drop_cnt_o+1; not defined: CRC byte ignored, no CRC-based drops.
REQ-030 CRC drop takes precedence over full-FIFO drop: a CRC-failing frame while full does not set overflow_o.

Verification
REQ-031 Active, empty; offer TLP 128'hA5..01 with CRC 8'h00, ready=1 -> tlp_valid_o=1 next cycle with 128'hA5..01, popped, rx_cnt_o=1.
REQ-032 Active, ready=0; offer 5 frames tagged 1..5 (depth 4) -> frames 1..4 buffered, frame 5 dropped, drop_cnt_o=1, overflow_o=1; then ready=1 -> 1,2,3,4 in order.
REQ-033 FIFO full, ready=1 and offer frame 9 same cycle -> head popped, frame 9 accepted, drop_cnt_o unchanged, occupancy stays 4.
REQ-034 2 frames buffered; dlc_state_i=2'b01 for one cycle with an offer -> FIFO empty, tlp_valid_o=0 next cycle, drop_cnt_o+1, rx_cnt_o unchanged.
REQ-035 With DLL_RX_CRC_CHK_EN: offer CRC 8'h5A -> not buffered, drop_cnt_o=1; without macro same stimulus -> buffered, rx_cnt_o=1.
REQ-036 Preload drop_cnt_o to 16'hFFFE via forced drops, force 3 more drops -> drop_cnt_o holds 16'hFFFF; rst_n=0 one edge -> all outputs zero.
